commutation_sequencer: RTL and testbench
========================================

Name: commutation_sequencer

Overview:
- Mode controller that sits ahead of the six-step commutation block and produces its 3-bit user-intent word UI: UI[2] is cw, UI[1] is ccw, UI[0] is regen brake.
- Arbitrates operator commands and inserts a dead-time coast whenever drive mode changes.
- Supervises the hall sensors. It forces the bridge off (UI=000) and latches a fault code on an invalid hall code, an illegal hall jump, or a stall.

Parameters:
DEADTIME, 8, number of coast cycles (UI=000) inserted on every mode change out of RUN_CW, RUN_CCW or BRAKE.
STALL_CYCLES, 1000, maximum cycles in a RUN state without a hall code change before a stall fault.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_cw  input  1  operator request: drive clockwise.
cmd_ccw  input  1  operator request: drive counter-clockwise.
cmd_brake  input  1  operator request: regenerative brake.
HS  input  3  raw hall sensor code.
UI  output  3  registered mode word to the commutation block.
state  output  3  FSM state: 0 IDLE, 1 RUN_CW, 2 RUN_CCW, 3 COAST, 4 BRAKE, 5 FAULT.
fault  output  1  high while in FAULT.
fault_code  output  2  0 none, 1 invalid hall, 2 illegal jump, 3 stall. Latched while in FAULT; cleared on exit.

Behaviour:
- Reset, and reset at any point mid-operation: next edge gives state=IDLE, UI=000, fault=0, fault_code=0; counters cleared; hs_q and hs_prev loaded with 000.
- HS is registered into hs_q every cycle. hs_prev holds the previous hs_q. All hall checks use hs_q and hs_prev.
- Request decode, in priority order:
  - brake if cmd_brake=1;
  - cw if cmd_cw=1 and cmd_ccw=0;
  - ccw if cmd_ccw=1 and cmd_cw=0;
  - none otherwise (cw and ccw both high counts as none).
- Outputs are registered. The state and UI for cycle N+1 are decided from inputs sampled at edge N.
- State and UI per state: IDLE 000, RUN_CW 100, RUN_CCW 010, COAST 000, BRAKE 001, FAULT 000.
- Transitions out of IDLE: brake goes to BRAKE; cw goes to RUN_CW; ccw goes to RUN_CCW. No dead-time from IDLE.
- RUN_CW, RUN_CCW and BRAKE:
  - stay while the request matches the state;
  - any other request goes to COAST and loads the dead-time counter with DEADTIME-1.
- COAST:
  - counts down; UI=000 for exactly DEADTIME cycles;
  - on the cycle the counter reads 0, sample the request: cw to RUN_CW, ccw to RUN_CCW, brake to BRAKE, none to IDLE;
  - request changes during the countdown do not restart it.
- Valid hall codes, in sequence: 100, 110, 010, 011, 001, 101 (cyclic). The codes 000 and 111 are invalid.
- Fault detection applies in every state except FAULT. Fault has priority over all other transitions.
  - Invalid hall: hs_q invalid for 2 consecutive cycles, giving fault_code=1. A single-cycle glitch is ignored.
  - Illegal jump: hs_q != hs_prev, both valid, and not adjacent in the cycle, giving fault_code=2.
  - Stall, in RUN_CW and RUN_CCW only:
    - the stall counter (width clog2(STALL_CYCLES+1)) clears on state entry and on every hall code change, and increments otherwise;
    - reaching STALL_CYCLES gives fault_code=3.
- Simultaneous faults on one edge: code priority is 1, then 2, then 3.
- FAULT: UI=000 and fault=1.
  - Exit to IDLE requires cmd_cw=cmd_ccw=cmd_brake=0 and hs_q valid on the same edge.
  - On exit, fault and fault_code clear. The exit edge does not consume a new request; the next request is handled from IDLE.
- No direct RUN_CW to RUN_CCW path. UI never shows 110, 101, 011 or 111.

Test Plan (bench uses DEADTIME=4, STALL_CYCLES=16):
- Reset, then cmd_cw=1 with HS stepping 100→110→010 every 5 cycles → one cycle after the request, UI=100 and state=1; fault=0 throughout.
- In RUN_CW, switch to cmd_ccw=1 → UI=000 and state=3 for exactly 4 cycles, then UI=010 and state=2.
- In RUN_CCW, assert cmd_brake=1 (ccw still high) → 4 cycles of UI=000, then UI=001. Drop all commands → 4 cycles of UI=000, then IDLE.
- In RUN_CW, hold HS=101 for 16 cycles → state=5, UI=000, fault_code=3. Release commands → IDLE on the next edge, fault=0.
- HS=111 for 1 cycle → no fault. HS=000 for 2 cycles → fault_code=1. HS jump 100→011 → fault_code=2.
- Assert rst during COAST and again during FAULT → next edge gives IDLE, UI=000, fault_code=0. A subsequent cmd_cw gives UI=100 with no coast.

Source files
------------

// File: rtl/commutation_sequencer.sv
// rtl/commutation_sequencer.sv - mode sequencer with dead-time coast and hall supervision
module commutation_sequencer #(
  parameter int DEADTIME     = 8,
  parameter int STALL_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_cw,
  input  logic       cmd_ccw,
  input  logic       cmd_brake,
  input  logic [2:0] HS,
  output logic [2:0] UI,
  output logic [2:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int SW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN_CW  = 3'd1,
    S_RUN_CCW = 3'd2,
    S_COAST   = 3'd3,
    S_BRAKE   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t        state_q;
  logic [2:0]    hs_q;
  logic [2:0]    hs_prev;
  logic          inv_q;
  logic [DW-1:0] dt_cnt;
  logic [SW-1:0] stall_cnt;

  // 000 and 111 can never come from a healthy sensor set
  function automatic logic hall_valid(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  // Position of a valid code in the 100,110,010,011,001,101 rotation
  function automatic logic [2:0] hall_idx(input logic [2:0] h);
    case (h)
      3'b100:  return 3'd0;
      3'b110:  return 3'd1;
      3'b010:  return 3'd2;
      3'b011:  return 3'd3;
      3'b001:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic hall_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] ia;
    logic [2:0] ib;
    ia = hall_idx(a);
    ib = hall_idx(b);
    return (ia == ((ib == 3'd5) ? 3'd0 : ib + 3'd1)) ||
           (ib == ((ia == 3'd5) ? 3'd0 : ia + 3'd1));
  endfunction

  function automatic logic [2:0] ui_of(input state_t s);
    case (s)
      S_RUN_CW:  return 3'b100;
      S_RUN_CCW: return 3'b010;
      S_BRAKE:   return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

  state_t     req_state;
  logic       hs_change;
  logic       in_run;
  logic       f_invalid;
  logic       f_jump;
  logic       f_stall;
  logic       fault_det;
  logic [1:0] det_code;

  // Request decode (brake wins, cw+ccw together is no request) and fault detection
  always_comb begin
    req_state = S_IDLE;
    if (cmd_brake)
      req_state = S_BRAKE;
    else if (cmd_cw && !cmd_ccw)
      req_state = S_RUN_CW;
    else if (cmd_ccw && !cmd_cw)
      req_state = S_RUN_CCW;

    hs_change = (hs_q != hs_prev);
    in_run    = (state_q == S_RUN_CW) || (state_q == S_RUN_CCW);
    f_invalid = !hall_valid(hs_q) && inv_q;
    f_jump    = hs_change && hall_valid(hs_q) && hall_valid(hs_prev) &&
                !hall_adjacent(hs_q, hs_prev);
    f_stall   = in_run && !hs_change && (stall_cnt == SW'(STALL_CYCLES - 1));
    fault_det = (state_q != S_FAULT) && (f_invalid || f_jump || f_stall);

    det_code = 2'd3;
    if (f_invalid)
      det_code = 2'd1;
    else if (f_jump)
      det_code = 2'd2;
  end

  // Hall pipeline; inv_q remembers that the previous hs_q was invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 3'b000;
      hs_prev <= 3'b000;
      inv_q   <= 1'b0;
    end else begin
      hs_q    <= HS;
      hs_prev <= hs_q;
      inv_q   <= !hall_valid(hs_q);
    end
  end

  // Mode FSM with registered UI, fault flag, fault code and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      UI         <= 3'b000;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      dt_cnt     <= '0;
      stall_cnt  <= '0;
    end else if (fault_det) begin
      state_q    <= S_FAULT;
      UI         <= 3'b000;
      fault      <= 1'b1;
      fault_code <= det_code;
      stall_cnt  <= '0;
    end else begin
      // Run states are only entered from non-run states, so holding the
      // counter at zero outside them also clears it on entry.
      if (!in_run || hs_change)
        stall_cnt <= '0;
      else
        stall_cnt <= stall_cnt + 1'b1;

      case (state_q)
        S_IDLE: begin
          state_q <= req_state;
          UI      <= ui_of(req_state);
        end
        S_RUN_CW, S_RUN_CCW, S_BRAKE: begin
          if (req_state != state_q) begin
            state_q <= S_COAST;
            UI      <= 3'b000;
            dt_cnt  <= DW'(DEADTIME - 1);
          end
        end
        S_COAST: begin
          if (dt_cnt == '0) begin
            state_q <= req_state;
            UI      <= ui_of(req_state);
          end else begin
            dt_cnt <= dt_cnt - 1'b1;
          end
        end
        S_FAULT: begin
          if (!cmd_cw && !cmd_ccw && !cmd_brake && hall_valid(hs_q)) begin
            state_q    <= S_IDLE;
            UI         <= 3'b000;
            fault      <= 1'b0;
            fault_code <= 2'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          UI      <= 3'b000;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// tb/tb_commutation_sequencer.sv - directed self-checking bench for commutation_sequencer
module tb_commutation_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_cw;
  logic       cmd_ccw;
  logic       cmd_brake;
  logic [2:0] HS;
  logic [2:0] UI;
  logic [2:0] state;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  commutation_sequencer #(.DEADTIME(4), .STALL_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_cw     (cmd_cw),
    .cmd_ccw    (cmd_ccw),
    .cmd_brake  (cmd_brake),
    .HS         (HS),
    .UI         (UI),
    .state      (state),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_cw = 1'b0; cmd_ccw = 1'b0; cmd_brake = 1'b0; HS = 3'b100;
    tick(); tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd0, 3'b000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset: got st/ui/f/fc=%b expected %b", {state, UI, fault, fault_code}, {3'd0, 3'b000, 1'b0, 2'd0});
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({state, UI, fault} !== {3'd0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", {state, UI, fault}, {3'd0, 3'b000, 1'b0});
    end
  endtask

  task automatic test_cw();
    logic [2:0] seq [3];
    seq = '{3'b100, 3'b110, 3'b010};
    cmd_cw = 1'b1;
    tick();
    checks++;
    if ({state, UI, fault} !== {3'd1, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL cw_entry: got %b expected %b", {state, UI, fault}, {3'd1, 3'b100, 1'b0});
    end
    for (int k = 0; k < 15; k++) begin
      HS = seq[k / 5];
      tick();
      checks++;
      if ({state, UI, fault} !== {3'd1, 3'b100, 1'b0}) begin
        errors++;
        $display("FAIL cw_run[%0d]: got %b expected %b", k, {state, UI, fault}, {3'd1, 3'b100, 1'b0});
      end
    end
  endtask

  task automatic test_coast_ccw();
    cmd_cw = 1'b0; cmd_ccw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({state, UI} !== {3'd3, 3'b000}) begin
        errors++;
        $display("FAIL coast_to_ccw[%0d]: got %b expected %b", i, {state, UI}, {3'd3, 3'b000});
      end
    end
    tick();
    checks++;
    if ({state, UI} !== {3'd2, 3'b010}) begin
      errors++;
      $display("FAIL ccw_entry: got %b expected %b", {state, UI}, {3'd2, 3'b010});
    end
  endtask

  task automatic test_brake();
    cmd_brake = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({state, UI} !== {3'd3, 3'b000}) begin
        errors++;
        $display("FAIL coast_to_brake[%0d]: got %b expected %b", i, {state, UI}, {3'd3, 3'b000});
      end
    end
    tick();
    checks++;
    if ({state, UI} !== {3'd4, 3'b001}) begin
      errors++;
      $display("FAIL brake_entry: got %b expected %b", {state, UI}, {3'd4, 3'b001});
    end
    cmd_brake = 1'b0; cmd_ccw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({state, UI} !== {3'd3, 3'b000}) begin
        errors++;
        $display("FAIL coast_to_idle[%0d]: got %b expected %b", i, {state, UI}, {3'd3, 3'b000});
      end
    end
    tick();
    checks++;
    if ({state, UI, fault} !== {3'd0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_coast: got %b expected %b", {state, UI, fault}, {3'd0, 3'b000, 1'b0});
    end
  endtask

  task automatic test_stall();
    logic [2:0] walk [3];
    walk = '{3'b011, 3'b001, 3'b101};
    for (int i = 0; i < 3; i++) begin
      HS = walk[i];
      tick(); tick();
    end
    checks++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL walk_idle: got %b expected %b", {state, fault}, {3'd0, 1'b0});
    end
    cmd_cw = 1'b1;
    tick();
    checks++;
    if ({state, UI} !== {3'd1, 3'b100}) begin
      errors++;
      $display("FAIL stall_entry: got %b expected %b", {state, UI}, {3'd1, 3'b100});
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if ({state, fault} !== {3'd1, 1'b0}) begin
        errors++;
        $display("FAIL stall_early[%0d]: got %b expected %b", i, {state, fault}, {3'd1, 1'b0});
      end
    end
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd5, 3'b000, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL stall_fault: got %b expected %b", {state, UI, fault, fault_code}, {3'd5, 3'b000, 1'b1, 2'd3});
    end
    tick();
    checks++;
    if ({state, fault_code} !== {3'd5, 2'd3}) begin
      errors++;
      $display("FAIL fault_hold_cmd: got %b expected %b", {state, fault_code}, {3'd5, 2'd3});
    end
    cmd_cw = 1'b0;
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd0, 3'b000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL stall_exit: got %b expected %b", {state, UI, fault, fault_code}, {3'd0, 3'b000, 1'b0, 2'd0});
    end
  endtask

  task automatic test_invalid();
    HS = 3'b111;
    tick();
    HS = 3'b101;
    tick(); tick(); tick();
    checks++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL glitch_ignored: got %b expected %b", {state, fault}, {3'd0, 1'b0});
    end
    HS = 3'b000;
    tick(); tick();
    checks++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL invalid_early: got %b expected %b", {state, fault}, {3'd0, 1'b0});
    end
    HS = 3'b101;
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd5, 3'b000, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL invalid_fault: got %b expected %b", {state, UI, fault, fault_code}, {3'd5, 3'b000, 1'b1, 2'd1});
    end
    tick();
    checks++;
    if ({state, fault, fault_code} !== {3'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL invalid_exit: got %b expected %b", {state, fault, fault_code}, {3'd0, 1'b0, 2'd0});
    end
  endtask

  task automatic test_jump();
    HS = 3'b100;
    tick(); tick(); tick();
    HS = 3'b011;
    tick();
    checks++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL jump_early: got %b expected %b", {state, fault}, {3'd0, 1'b0});
    end
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd5, 3'b000, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL jump_fault: got %b expected %b", {state, UI, fault, fault_code}, {3'd5, 3'b000, 1'b1, 2'd2});
    end
    tick();
    checks++;
    if ({state, fault, fault_code} !== {3'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL jump_exit: got %b expected %b", {state, fault, fault_code}, {3'd0, 1'b0, 2'd0});
    end
  endtask

  task automatic test_reset_mid();
    cmd_cw = 1'b1;
    tick();
    cmd_cw = 1'b0; cmd_ccw = 1'b1;
    tick();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL mid_coast: got %0d expected 3", state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd0, 3'b000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_coast: got %b expected %b", {state, UI, fault, fault_code}, {3'd0, 3'b000, 1'b0, 2'd0});
    end
    rst = 1'b0; cmd_ccw = 1'b0; HS = 3'b011;
    tick(); tick();
    HS = 3'b000;
    tick(); tick();
    HS = 3'b011;
    tick();
    checks++;
    if ({state, fault_code} !== {3'd5, 2'd1}) begin
      errors++;
      $display("FAIL fault_before_reset: got %b expected %b", {state, fault_code}, {3'd5, 2'd1});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({state, UI, fault, fault_code} !== {3'd0, 3'b000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_fault: got %b expected %b", {state, UI, fault, fault_code}, {3'd0, 3'b000, 1'b0, 2'd0});
    end
    rst = 1'b0; cmd_cw = 1'b1;
    tick();
    checks++;
    if ({state, UI} !== {3'd1, 3'b100}) begin
      errors++;
      $display("FAIL cw_after_reset: got %b expected %b", {state, UI}, {3'd1, 3'b100});
    end
    tick();
    checks++;
    if ({state, UI, fault} !== {3'd1, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL cw_hold_after_reset: got %b expected %b", {state, UI, fault}, {3'd1, 3'b100, 1'b0});
    end
    cmd_cw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cw();
    test_coast_ccw();
    test_brake();
    test_stall();
    test_invalid();
    test_jump();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
